// File: rtl/matmul_output_drain.sv
// Result drain for the 4x4 systolic matmul array: snapshots the accumulators on the
// rising edge of done_mat_mul, then writes saturated rows to C memory over valid/ready.
module matmul_output_drain #(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 7,
  parameter int MAT_MUL_SIZE = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          done_mat_mul,
  input  logic [MAT_MUL_SIZE*MAT_MUL_SIZE*2*DWIDTH-1:0] matrix_c_in,
  input  logic [7:0]                                    final_mat_mul_size,
  input  logic [AWIDTH-1:0]                             c_base,
  input  logic                                          c_ready,
  output logic                                          c_wen,
  output logic [AWIDTH-1:0]                             c_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]                c_data,
  output logic                                          busy,
  output logic                                          drain_done,
  output logic                                          overrun
);

  localparam int AW2 = 2 * DWIDTH;
  localparam int NE  = MAT_MUL_SIZE * MAT_MUL_SIZE;
  localparam int RW  = $clog2(MAT_MUL_SIZE);
  localparam int NW  = $clog2(MAT_MUL_SIZE + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic                       done_q, done_d;
  logic [NE*AW2-1:0]          snap_q, snap_d;
  logic [AWIDTH-1:0]          c_base_q, c_base_d;
  logic [NW-1:0]              n_q, n_d;
  logic [RW-1:0]              row_q, row_d;
  logic                       c_wen_q, c_wen_d;
  logic [AWIDTH-1:0]          c_addr_q, c_addr_d;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] c_data_q, c_data_d;
  logic                       busy_q, busy_d;
  logic                       drain_done_q, drain_done_d;
  logic                       overrun_q, overrun_d;

  logic                       trigger;
  logic [NW-1:0]              n_in;
  logic [RW-1:0]              row_nxt;

  function automatic logic [DWIDTH-1:0] sat(input logic [AW2-1:0] v);
    logic [AW2-DWIDTH:0] top;
    top = v[AW2-1:DWIDTH-1];
    if ((&top) || !(|top)) return v[DWIDTH-1:0];
    else if (v[AW2-1])     return {1'b1, {(DWIDTH-1){1'b0}}};
    else                   return {1'b0, {(DWIDTH-1){1'b1}}};
  endfunction

  // Columns at or beyond the active dimension are forced to zero.
  function automatic logic [MAT_MUL_SIZE*DWIDTH-1:0] row_sat(
    input logic [NE*AW2-1:0] m,
    input logic [RW-1:0]     r,
    input logic [NW-1:0]     n
  );
    logic [MAT_MUL_SIZE*DWIDTH-1:0] out;
    out = '0;
    for (int unsigned j = 0; j < MAT_MUL_SIZE; j++) begin
      if (j < 32'(n))
        out[j*DWIDTH +: DWIDTH] = sat(m[(32'(r) * MAT_MUL_SIZE + j) * AW2 +: AW2]);
    end
    return out;
  endfunction

  assign trigger = done_mat_mul && !done_q;
  assign n_in    = (final_mat_mul_size > 8'(MAT_MUL_SIZE)) ? NW'(MAT_MUL_SIZE)
                                                           : NW'(final_mat_mul_size);
  assign row_nxt = row_q + RW'(1);

  always_comb begin
    state_d      = state_q;
    done_d       = done_mat_mul;
    snap_d       = snap_q;
    c_base_d     = c_base_q;
    n_d          = n_q;
    row_d        = row_q;
    c_wen_d      = c_wen_q;
    c_addr_d     = c_addr_q;
    c_data_d     = c_data_q;
    busy_d       = busy_q;
    drain_done_d = 1'b0;
    overrun_d    = overrun_q;

    if (trigger && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          snap_d   = matrix_c_in;
          c_base_d = c_base;
          n_d      = n_in;
          row_d    = '0;
          busy_d   = 1'b1;
          if (n_in == '0) begin
            state_d      = S_DONE;
            drain_done_d = 1'b1;
          end else begin
            // First row comes straight from the input so c_wen rises one cycle after capture.
            state_d  = S_WRITE;
            c_wen_d  = 1'b1;
            c_addr_d = c_base;
            c_data_d = row_sat(matrix_c_in, '0, n_in);
          end
        end
      end
      S_WRITE: begin
        if (c_ready) begin
          if (NW'(row_q) == n_q - NW'(1)) begin
            state_d      = S_DONE;
            c_wen_d      = 1'b0;
            drain_done_d = 1'b1;
          end else begin
            row_d    = row_nxt;
            c_addr_d = c_base_q + AWIDTH'(row_nxt);
            c_data_d = row_sat(snap_q, row_nxt, n_q);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      snap_q       <= '0;
      c_base_q     <= '0;
      n_q          <= '0;
      row_q        <= '0;
      c_wen_q      <= 1'b0;
      c_addr_q     <= '0;
      c_data_q     <= '0;
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      snap_q       <= snap_d;
      c_base_q     <= c_base_d;
      n_q          <= n_d;
      row_q        <= row_d;
      c_wen_q      <= c_wen_d;
      c_addr_q     <= c_addr_d;
      c_data_q     <= c_data_d;
      busy_q       <= busy_d;
      drain_done_q <= drain_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign c_wen      = c_wen_q;
  assign c_addr     = c_addr_q;
  assign c_data     = c_data_q;
  assign busy       = busy_q;
  assign drain_done = drain_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_matmul_output_drain.sv
// Scoreboard bench for matmul_output_drain: expected rows are queued at issue time
// and popped by an independent monitor on every accepted write beat.
module tb_matmul_output_drain;

  logic         clk = 1'b0;
  logic         reset;
  logic         done_mat_mul;
  logic [511:0] matrix_c_in;
  logic [7:0]   final_mat_mul_size;
  logic [6:0]   c_base;
  logic         c_ready;
  logic         c_wen;
  logic [6:0]   c_addr;
  logic [63:0]  c_data;
  logic         busy;
  logic         drain_done;
  logic         overrun;

  matmul_output_drain #(.DWIDTH(16), .AWIDTH(7), .MAT_MUL_SIZE(4)) dut (
    .clk(clk), .reset(reset), .done_mat_mul(done_mat_mul), .matrix_c_in(matrix_c_in),
    .final_mat_mul_size(final_mat_mul_size), .c_base(c_base), .c_ready(c_ready),
    .c_wen(c_wen), .c_addr(c_addr), .c_data(c_data), .busy(busy),
    .drain_done(drain_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done_cnt = 0;
  int  checks = 0;
  int  fails = 0;
  logic exp_overrun = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: saturate a signed 32-bit accumulator to 16 bits by value range.
  function automatic logic [63:0] model_row(input logic [511:0] m, input int i, input int neff);
    logic [63:0] r;
    logic [31:0] w;
    longint      v;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < neff) begin
        w = m[(i*4+j)*32 +: 32];
        v = longint'($signed(w));
        if (v > 32767)       r[j*16 +: 16] = 16'h7fff;
        else if (v < -32768) r[j*16 +: 16] = 16'h8000;
        else                 r[j*16 +: 16] = w[15:0];
      end
    end
    return r;
  endfunction

  function automatic logic [511:0] rand_matrix();
    logic [511:0] m;
    logic [31:0]  w;
    for (int e = 0; e < 16; e++) begin
      case ($urandom_range(0, 3))
        0: w = $urandom;
        1: begin w[15:0] = 16'($urandom); w[31:16] = {16{w[15]}}; end
        2: case ($urandom_range(0, 3))
             0: w = 32'h0000_7fff;
             1: w = 32'h0000_8000;
             2: w = 32'hffff_8000;
             default: w = 32'hffff_7fff;
           endcase
        default: w = 32'($urandom_range(0, 70000)) - 32'd35000;
      endcase
      m[e*32 +: 32] = w;
    end
    return m;
  endfunction

  // Monitor: pops the scoreboard on each accepted beat, checks stall stability.
  logic        prev_stall = 1'b0;
  logic [6:0]  prev_addr;
  logic [63:0] prev_data;
  always @(negedge clk) begin
    wr_t e;
    if (reset !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {8'b0, c_wen, c_addr, c_data}, {8'b0, 1'b1, prev_addr, prev_data});
      if (c_wen && c_ready) begin
        if (exp_wr.size() == 0) begin
          chk("write_expected", 80'(exp_wr.size() != 0), 80'd1);
        end else begin
          e = exp_wr.pop_front();
          chk("c_addr", 80'(c_addr), 80'(e.addr));
          chk("c_data", 80'(c_data), 80'(e.data));
        end
      end
      if (drain_done) begin
        chk("drain_done_expected", 80'({exp_done_cnt > 0, exp_wr.size() == 0}), 80'b11);
        if (exp_done_cnt > 0) exp_done_cnt--;
      end
      prev_stall = c_wen && !c_ready;
      prev_addr  = c_addr;
      prev_data  = c_data;
    end
  end

  // One tile: queue expectations, trigger, drive ready from rpat, check timing.
  task automatic drain(input logic [511:0] m, input logic [7:0] n, input logic [6:0] base,
                       input logic [31:0] rpat, input int retrig, input int abort_at);
    int   neff, acc, exp_k, k;
    logic busy_ok, seen;
    neff = (n > 8'd4) ? 4 : int'(n);
    for (int i = 0; i < neff; i++)
      exp_wr.push_back('{addr: 7'(int'(base) + i), data: model_row(m, i, neff)});
    exp_k = 1;
    acc = 0;
    if (neff > 0) begin
      for (int c = 1; c < 200; c++) begin
        if (rpat[(c-1) % 32]) acc++;
        if (acc == neff) begin exp_k = c + 1; break; end
      end
    end
    if (abort_at == 0) exp_done_cnt++;
    matrix_c_in        = m;
    final_mat_mul_size = n;
    c_base             = base;
    @(posedge clk); #1;
    done_mat_mul = 1'b1;
    @(posedge clk); #1;
    k = 1; busy_ok = 1'b1; seen = 1'b0;
    while (k < 200) begin
      c_ready = rpat[(k-1) % 32];
      if (k == retrig) begin
        done_mat_mul = 1'b1;
        matrix_c_in  = rand_matrix();
        exp_overrun  = 1'b1;
      end else begin
        done_mat_mul = 1'b0;
      end
      if (abort_at == k) begin reset = 1'b0; break; end
      if (!busy) busy_ok = 1'b0;
      if (drain_done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      k++;
    end
    if (abort_at != 0) begin
      @(posedge clk); #1;
      chk("abort_outputs", {7'b0, c_wen, c_addr, c_data, busy, drain_done, overrun},
          80'd0);
      exp_wr.delete();
      exp_overrun = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end else begin
      chk("drain_cycle", 80'(k), 80'(exp_k));
      chk("busy_during", 80'({busy_ok, seen}), 80'b11);
      @(posedge clk); #1;
      done_mat_mul = 1'b0;
      chk("post_idle", 80'({busy, drain_done, overrun}), 80'({2'b00, exp_overrun}));
      chk("queue_drained", 80'(exp_wr.size()), 80'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [511:0] m;
    reset = 1'b0; done_mat_mul = 1'b0; matrix_c_in = '0; final_mat_mul_size = 8'd4;
    c_base = '0; c_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {7'b0, c_wen, c_addr, c_data, busy, drain_done, overrun}, 80'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int e = 0; e < 16; e++) m[e*32 +: 32] = 32'(e);
    drain(m, 8'd4, 7'h10, 32'hffff_ffff, 0, 0);

    m = rand_matrix();
    m[31:0] = 32'h0001_0000; m[63:32] = 32'hffff_0000;
    m[95:64] = 32'h0000_7fff; m[127:96] = 32'hffff_8000;
    drain(m, 8'd4, 7'h20, 32'hffff_ffff, 0, 0);

    drain(rand_matrix(), 8'd2, 7'h30, 32'hffff_ffff, 0, 0);
    drain(rand_matrix(), 8'd9, 7'h40, 32'hffff_ffff, 0, 0);
    drain(rand_matrix(), 8'd0, 7'h50, 32'hffff_ffff, 0, 0);
    drain(rand_matrix(), 8'd4, 7'h05, 32'hffff_ffd9, 0, 0);
    drain(rand_matrix(), 8'd4, 7'h60, $urandom | 32'h1, 2, 0);

    drain(rand_matrix(), 8'd4, 7'h08, 32'hffff_ffff, 0, 3);
    drain(rand_matrix(), 8'd4, 7'h18, 32'hffff_ffff, 0, 0);

    drain(rand_matrix(), 8'd4, 7'h28, 32'hffff_ffff, 5, 0);
    drain(rand_matrix(), 8'd4, 7'h7e, 32'hffff_ffff, 0, 0);

    for (int t = 0; t < 20; t++)
      drain(rand_matrix(), 8'($urandom_range(0, 9)), 7'($urandom), $urandom | 32'h1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_idle", 80'({c_wen, busy, drain_done, exp_done_cnt == 0}), 80'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
